regfile_wb_ctrl: RTL

Writeback controller for the register file's single write port. Arbitrates between NReq writeback requesters (ALU, load unit, CSR unit) round-robin, and drives a registered write stage into the register file write port. Holds a per-register busy scoreboard: issue sets a bit, writeback clears it. Decode/issue queries the scoreboard for RAW/WAW stalls.

---
 rtl/rv32_isa_pkg.sv | 22 ++
 rtl/regfile_wb_ctrl_arb.sv | 55 +++++
 rtl/regfile_wb_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/rv32_isa_pkg.sv
// rv32_isa: shared RV32 architectural constants and writeback bundle types.
//   RegWidth      - architectural register width
//   RegAddrWidth  - register index width (32 registers, x0 hardwired zero)
//   wb_req_t      - packed writeback request: destination address + data
//   wb_src_e      - conventional requester slot ordering on the writeback bus
package rv32_isa;

  localparam int unsigned RegWidth     = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegWidth-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// rr_arbiter: N-way round-robin arbiter with registered priority pointer.
//   clk_i, rst_ni  - clock, synchronous active-low reset (pointer -> 0)
//   req_i          - per-requester request
//   gnt_o          - one-hot grant, first requester at/after the pointer
//   gnt_idx_o      - index of the granted requester (valid with gnt_valid_o)
//   gnt_valid_o    - a grant was issued this cycle
// The pointer moves to (granted index + 1) mod N only when a grant is issued.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] scan_idx;

  // Scan N slots starting at the pointer; the first requester seen wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = IdxW'((32'(ptr_q) + k) % N);
      if (!gnt_valid_o && req_i[scan_idx]) begin
        gnt_valid_o     = 1'b1;
        gnt_o[scan_idx] = 1'b1;
        gnt_idx_o       = scan_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = IdxW'((32'(gnt_idx_o) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback controller for the register file write port.
//   iClk, nRst         - clock, synchronous active-low reset
//   iReqValid/Addr/Data- NReq writeback requesters; oReqReady is a one-hot grant
//   iIssueValid/Rd     - issue marks iIssueRd busy
//   iAddr_Rs1/Rs2      - scoreboard queries -> oRs1Busy/oRs2Busy; oRdBusy for WAW
//   oWriteEn/oAddr_Rd/oRd - registered register file write port (1-cycle latency)
//   oIdle              - no busy registers and no write in progress
module regfile_wb_ctrl
  import rv32_isa::*;
#(
  parameter int unsigned NReq  = 3,
  parameter int unsigned NRegs = 32
) (
  input  logic                                iClk,
  input  logic                                nRst,
  input  logic [NReq-1:0]                     iReqValid,
  input  logic [NReq-1:0][RegAddrWidth-1:0]   iReqAddr,
  input  logic [NReq-1:0][RegWidth-1:0]       iReqData,
  output logic [NReq-1:0]                     oReqReady,
  input  logic                                iIssueValid,
  input  logic [RegAddrWidth-1:0]             iIssueRd,
  input  logic [RegAddrWidth-1:0]             iAddr_Rs1,
  input  logic [RegAddrWidth-1:0]             iAddr_Rs2,
  output logic                                oRs1Busy,
  output logic                                oRs2Busy,
  output logic                                oRdBusy,
  output logic                                oWriteEn,
  output logic [RegAddrWidth-1:0]             oAddr_Rd,
  output logic [RegWidth-1:0]                 oRd,
  output logic                                oIdle
);

  logic [$clog2(NReq)-1:0] gnt_idx;
  logic                    xfer;
  wb_req_t                 sel;

  logic                    wen_q, wen_d;
  logic [RegAddrWidth-1:0] waddr_q, waddr_d;
  logic [RegWidth-1:0]     wdata_q, wdata_d;
  logic [NRegs-1:0]        busy_q, busy_d;

  rr_arbiter #(
    .N (NReq)
  ) u_arb (
    .clk_i       (iClk),
    .rst_ni      (nRst),
    .req_i       (iReqValid),
    .gnt_o       (oReqReady),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (xfer)
  );

  always_comb begin
    sel.addr = iReqAddr[gnt_idx];
    sel.data = iReqData[gnt_idx];
  end

  // x0 transfers are accepted and captured but never raise the write enable.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      wen_d   = |sel.addr;
      waddr_d = sel.addr;
      wdata_d = sel.data;
    end
  end

  // Clear first, then set, so an issue colliding with the retiring write wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (iIssueValid && (|iIssueRd)) begin
      busy_d[iIssueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign oWriteEn = wen_q;
  assign oAddr_Rd = waddr_q;
  assign oRd      = wdata_q;

  assign oRs1Busy = (|iAddr_Rs1) && busy_q[iAddr_Rs1];
  assign oRs2Busy = (|iAddr_Rs2) && busy_q[iAddr_Rs2];
  assign oRdBusy  = (|iIssueRd)  && busy_q[iIssueRd];
  assign oIdle    = !(|busy_q) && !wen_q;

endmodule
